// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: assembles WIDTH-bit words from a strobed bit
// stream and presents them on a registered valid/ready output with a sticky overrun flag.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     d,
  input  logic                     d_en,
  input  logic                     clr,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  input  logic                     q_ready,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_valid;
  logic             r_ovr;

  logic [WIDTH-1:0] w_shift;
  logic             w_last;
  logic             w_accept;

  // Next shift-register value with the current bit inserted in the configured order.
  always_comb begin
    w_shift = r_sr;
    if (MSB_FIRST) begin
      w_shift = {r_sr[WIDTH-2:0], d};
    end else begin
      w_shift = {d, r_sr[WIDTH-1:1]};
    end
  end

  assign w_last   = d_en && (r_cnt == LAST_CNT);
  assign w_accept = r_valid && q_ready;

  // Shift, count, word hand-off and overrun tracking; clr overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr    <= {WIDTH{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (clr) begin
      r_sr    <= {WIDTH{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (d_en) begin
        r_sr  <= w_shift;
        r_cnt <= w_last ? {CW{1'b0}} : (r_cnt + CW'(1));
      end
      if (w_last) begin
        // A completing word may replace q only if the slot is empty or drained this edge.
        if (!r_valid || q_ready) begin
          r_q     <= w_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign q       = r_q;
  assign q_valid = r_valid;
  assign overrun = r_ovr;
  assign bit_cnt = r_cnt;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench: directed scenarios plus random traffic on MSB-first and
// LSB-first instances, checked against a queue-based word model.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d = 1'b0;
  logic       d_en = 1'b0;
  logic       clr = 1'b0;
  logic       q_ready = 1'b0;
  logic [7:0] q_m, q_l;
  logic       v_m, v_l, o_m, o_l;
  logic [2:0] c_m, c_l;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit        bits[$];
  bit [7:0]  e_qm, e_ql;
  bit        e_v, e_o;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .d(d), .d_en(d_en), .clr(clr),
    .q(q_m), .q_valid(v_m), .q_ready(q_ready), .overrun(o_m), .bit_cnt(c_m)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .d(d), .d_en(d_en), .clr(clr),
    .q(q_l), .q_valid(v_l), .q_ready(q_ready), .overrun(o_l), .bit_cnt(c_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    e_qm = 8'h00; e_ql = 8'h00; e_v = 1'b0; e_o = 1'b0;
  endtask

  task automatic model_edge(input bit dd, input bit en, input bit c, input bit rdy);
    bit done;
    int wm, wl;
    done = 1'b0;
    if (c) begin
      model_reset();
    end else begin
      if (en) begin
        bits.push_back(dd);
        if (bits.size() == 8) begin
          wm = 0; wl = 0;
          for (int i = 0; i < 8; i++) begin
            wm = wm * 2 + int'(bits[i]);
            wl = wl + (int'(bits[i]) << i);
          end
          bits.delete();
          done = 1'b1;
          if (!e_v || rdy) begin
            e_qm = wm[7:0]; e_ql = wl[7:0]; e_v = 1'b1;
          end else begin
            e_o = 1'b1;
          end
        end
      end
      if (!done && e_v && rdy) e_v = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("q_msb", 32'(q_m), 32'(e_qm));
    chk("q_lsb", 32'(q_l), 32'(e_ql));
    chk("valid_msb", 32'(v_m), 32'(e_v));
    chk("valid_lsb", 32'(v_l), 32'(e_v));
    chk("ovr_msb", 32'(o_m), 32'(e_o));
    chk("ovr_lsb", 32'(o_l), 32'(e_o));
    chk("cnt_msb", 32'(c_m), 32'(bits.size()));
    chk("cnt_lsb", 32'(c_l), 32'(bits.size()));
  endtask

  task automatic step(input bit dd, input bit en, input bit c, input bit rdy);
    d = dd; d_en = en; clr = c; q_ready = rdy;
    @(posedge clk);
    model_edge(dd, en, c, rdy);
    #1;
    compare_all();
  endtask

  // Asserted between edges; outputs must clear without any clock edge.
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_q_now", 32'(q_m), 32'h0);
    chk("rst_cnt_now", 32'(c_m), 32'h0);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] val, input bit rdy, input bit gapped);
    logic [7:0] v;
    v = val;
    for (int i = 7; i >= 0; i--) begin
      step(v[i], 1'b1, 1'b0, rdy);
      if (gapped) step(~v[i], 1'b0, 1'b0, rdy);
    end
  endtask

  initial begin
    model_reset();
    #2;
    compare_all();
    chk("reset_valid", 32'(v_m), 32'h0);
    rst_n = 1'b1;

    // Reset mid-word, then a fresh word
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    async_reset();
    send_byte(8'hA5, 1'b0, 1'b0);
    chk("a5_q", 32'(q_m), 32'hA5);
    chk("a5_valid", 32'(v_m), 32'h1);

    // Bit order: drain then send CA
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_byte(8'hCA, 1'b0, 1'b0);
    chk("ca_msb", 32'(q_m), 32'hCA);
    chk("ca_lsb", 32'(q_l), 32'h53);

    // Gapped strobe
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_byte(8'hCA, 1'b0, 1'b1);
    chk("gap_q", 32'(q_m), 32'hCA);

    // Back-to-back with ready held high
    send_byte(8'h3C, 1'b1, 1'b0);
    chk("b2b_q1", 32'(q_m), 32'h3C);
    send_byte(8'hF0, 1'b1, 1'b0);
    chk("b2b_q2", 32'(q_m), 32'hF0);
    chk("b2b_valid", 32'(v_m), 32'h1);
    chk("b2b_ovr", 32'(o_m), 32'h0);

    // Overrun
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    chk("ovr_q", 32'(q_m), 32'h11);
    chk("ovr_flag", 32'(o_m), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_drain_valid", 32'(v_m), 32'h0);
    chk("ovr_sticky", 32'(o_m), 32'h1);

    // Clear priority with valid, overrun and bit_cnt=5
    send_byte(8'h44, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre_clr_cnt", 32'(c_m), 32'h5);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_q", 32'(q_m), 32'h0);
    chk("clr_valid", 32'(v_m), 32'h0);
    chk("clr_ovr", 32'(o_m), 32'h0);
    chk("clr_cnt", 32'(c_m), 32'h0);
    send_byte(8'h5A, 1'b0, 1'b0);
    chk("post_clr_q", 32'(q_m), 32'h5A);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
